// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - 3-stage pipelined floating-point multiplier, flush-to-zero, round-to-nearest-even
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS_X  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EXP_SAT = XW'((1 << EXP_W) - 1);
    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    function automatic logic [1:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '1)
            classify = (m == '0) ? CLS_INF : CLS_NAN;
        else if (e == '0)
            classify = CLS_ZERO;
        else
            classify = CLS_NORM;
    endfunction

    logic            adv;
    logic [1:0]      cls_a, cls_b, cls_ab;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_sign_q, s1_sign_d;
    logic [1:0]      s1_cls_q, s1_cls_d;
    logic [XW-1:0]   s1_exp_q, s1_exp_d;
    logic [MAN_W:0]  s1_ma_q, s1_ma_d;
    logic [MAN_W:0]  s1_mb_q, s1_mb_d;

    logic            s2_valid_q, s2_valid_d;
    logic            s2_sign_q, s2_sign_d;
    logic [1:0]      s2_cls_q, s2_cls_d;
    logic [XW-1:0]   s2_exp_q, s2_exp_d;
    logic [PW-1:0]   s2_prod_q, s2_prod_d;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    y_q, y_d;
    logic [2:0]      flags_q, flags_d;

    logic            msb, guard, sticky, rnd;
    logic [PW-2:0]   norm;
    logic [MAN_W-1:0] man_t;
    logic [MAN_W:0]  man_r;
    logic [XW-1:0]   exp_f;
    logic [W-1:0]    res_y;
    logic [2:0]      res_flags;

    // S3: normalise, round, then resolve special classes and exponent range
    always_comb begin
        msb    = s2_prod_q[PW-1];
        norm   = msb ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
        man_t  = norm[PW-2 -: MAN_W];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        rnd    = guard & (sticky | man_t[0]);
        man_r  = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd};
        exp_f  = s2_exp_q + {{(XW-1){1'b0}}, msb} + {{(XW-1){1'b0}}, man_r[MAN_W]};
        res_y     = '0;
        res_flags = 3'b000;
        case (s2_cls_q)
            CLS_NAN: begin
                res_y     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                res_flags = 3'b100;
            end
            CLS_INF:  res_y = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: res_y = {s2_sign_q, {(W-1){1'b0}}};
            default: begin
                if ($signed(exp_f) >= $signed(EXP_SAT)) begin
                    res_y     = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    res_flags = 3'b010;
                end else if (exp_f[XW-1] || exp_f == '0) begin
                    res_y     = {s2_sign_q, {(W-1){1'b0}}};
                    res_flags = 3'b001;
                end else begin
                    res_y = {s2_sign_q, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
                end
            end
        endcase
    end

    always_comb begin
        adv   = !out_valid_q || out_ready;
        cls_a = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
        cls_b = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF) || (cls_a == CLS_INF && cls_b == CLS_ZERO))
            cls_ab = CLS_NAN;
        else if (cls_a == CLS_INF || cls_b == CLS_INF)
            cls_ab = CLS_INF;
        else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
            cls_ab = CLS_ZERO;
        else
            cls_ab = CLS_NORM;

        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_cls_d    = s1_cls_q;
        s1_exp_d    = s1_exp_q;
        s1_ma_d     = s1_ma_q;
        s1_mb_d     = s1_mb_q;
        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_cls_d    = s2_cls_q;
        s2_exp_d    = s2_exp_q;
        s2_prod_d   = s2_prod_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        flags_d     = flags_q;

        // Whole pipe moves as one; a stalled output freezes every stage
        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = a[W-1] ^ b[W-1];
                s1_cls_d  = cls_ab;
                s1_exp_d  = XW'(a[W-2 -: EXP_W]) + XW'(b[W-2 -: EXP_W]) - BIAS_X;
                s1_ma_d   = {1'b1, a[MAN_W-1:0]};
                s1_mb_d   = {1'b1, b[MAN_W-1:0]};
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d = s1_sign_q;
                s2_cls_d  = s1_cls_q;
                s2_exp_d  = s1_exp_q;
                s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
            end
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                y_d     = res_y;
                flags_d = res_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_cls_q    <= CLS_ZERO;
            s1_exp_q    <= '0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_cls_q    <= CLS_ZERO;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= 3'b000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_cls_q    <= s1_cls_d;
            s1_exp_q    <= s1_exp_d;
            s1_ma_q     <= s1_ma_d;
            s1_mb_q     <= s1_mb_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_cls_q    <= s2_cls_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flags     = flags_q;

endmodule

// File: doc/fp_mult_pipe.md
FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a  input  W  operand A, IEEE-754-style {sign, exp, man}.
REQ-006 SHALL have port b  input  W  operand B, same format.
REQ-007 SHALL have port in_valid  input  1  a/b valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts a/b this cycle.
REQ-009 SHALL have port y  output  W  registered product.
REQ-010 SHALL have port out_valid  output  1  y valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts y.
REQ-012 SHALL have port flags  output  3  {invalid, overflow, underflow}, registered alongside y.

Function
REQ-013 SHALL be a 3-stage pipeline: S1 unpack/classify, S2 mantissa multiply, S3 normalise/round/pack; each stage has its own valid bit.
REQ-014 SHALL use a global advance: adv = !out_valid | out_ready; in_ready = adv; all stages shift only when adv=1.
REQ-015 SHALL capture an operand pair when in_valid & in_ready; y/out_valid appear 3 adv cycles later (latency 3 with no stall).
REQ-016 SHALL hold y, flags, and all stage contents unchanged while adv=0; no transfer lost or duplicated.
REQ-017 SHALL accept a new pair every cycle while out_ready=1 (throughput 1/cycle).
REQ-018 SHALL compute result sign = sign(a) XOR sign(b) for all non-NaN results.
REQ-019 SHALL treat exp=0 operands (zero and subnormal) as signed zero (flush-to-zero).
REQ-020 SHALL output canonical NaN (sign 0, exp all ones, man MSB 1, rest 0) with invalid=1 if either input is NaN, or for zero x infinity.
REQ-021 SHALL output signed infinity, with no flags, for infinity x non-zero finite or infinity x infinity.
REQ-022 SHALL output signed zero, with no flags, for zero x finite.
REQ-023 SHALL, for normal operands, form the (MAN_W+1)x(MAN_W+1) product of the hidden-1 mantissas at full 2*(MAN_W+1) width, with exponent ea+eb-bias (bias = 2^(EXP_W-1)-1) held in EXP_W+2 signed bits.
REQ-024 SHALL normalise by 1 right shift (exp+1) when the product MSB is set.
REQ-025 SHALL round to nearest, ties to even, using guard bit plus sticky OR of all lower bits; rounding carry-out SHALL renormalise (exp+1).
REQ-026 SHALL saturate to signed infinity with overflow=1 when the final exp >= 2^EXP_W-1.
REQ-027 SHALL flush to signed zero with underflow=1 when the final exp <= 0.
REQ-028 SHALL drive flags=0 for every exact or normally rounded result.

Reset
REQ-029 SHALL, while rst_n=0, immediately clear all stage valid bits, out_valid=0, y=0, and flags=0; in_ready then equals 1.
REQ-030 SHALL discard all in-flight operations on reset assertion mid-stream; the first out_valid after release comes from a post-reset input.

Verification
REQ-031 Bench SHALL cover default params: a=b=0x3F800000, out_ready=1 -> y=0x3F800000, flags=000, out_valid exactly 3 cycles after acceptance.
REQ-032 Bench SHALL cover a back-to-back stream of 0x40000000*0x40400000, then 0x00000000*0x7F800000, then 0x7F000000*0x7F000000, then 0x00800000*0x00800000 -> results in order: 0x40C00000/000, 0x7FC00000/100, 0x7F800000/010, 0x00000000/001.
REQ-033 Bench SHALL cover rounding: 0x3F800001*0x3F800001 -> 0x3F800002, and 0xBF800000*0x3FC00000 -> 0xBFC00000.
REQ-034 Bench SHALL cover backpressure: 4 pairs issued, out_ready=0 for 5 cycles -> in_ready=0 once out_valid=1, y stable, then all 4 results are delivered in order with none lost.
REQ-035 Bench SHALL cover EXP_W=5, MAN_W=10: 0x3C00*0x4000 -> 0x4000, and 0x7BFF*0x4000 -> 0x7C00 with overflow=1.
REQ-036 Bench SHALL cover reset mid-stream: rst_n pulled low with 2 ops in flight -> out_valid=0 and y=0 asynchronously, and no stale results after release.
